// File: rtl/keypad_entry_if.sv
// Keypad entry controller bundle: scanner code in, BCD entry and submit handshake out.
// The slave modport is the controller; the master modport is the scanner/consumer side.
interface keypad_entry_if #(
  parameter int unsigned MAX_DIGITS = 4
);
  logic [3:0]                         key_code_in;
  logic [4*MAX_DIGITS-1:0]            digits;
  logic [$clog2(MAX_DIGITS+1)-1:0]    digit_cnt;
  logic                               key_evt;
  logic [3:0]                         key_evt_code;
  logic                               overflow;
  logic                               code_valid;
  logic                               code_ready;

  modport master (
    output key_code_in, code_ready,
    input  digits, digit_cnt, key_evt, key_evt_code, overflow, code_valid
  );

  modport slave (
    input  key_code_in, code_ready,
    output digits, digit_cnt, key_evt, key_evt_code, overflow, code_valid
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Keypad press qualifier and BCD entry assembler with valid/ready submit.
// Optional macro KEYPAD_BACKSPACE_EN turns '*' into backspace (double '*' clears).
module keypad_entry_ctrl #(
  parameter int unsigned MAX_DIGITS     = 4,
  parameter int unsigned PRESS_HITS     = 3,
  parameter int unsigned RELEASE_CYCLES = 8
) (
  input logic           clk,
  input logic           rst,
  keypad_entry_if.slave io_kp
);
  localparam int unsigned CntW  = $clog2(MAX_DIGITS + 1);
  localparam int unsigned HitW  = $clog2(PRESS_HITS + 1);
  localparam int unsigned IdleW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [3:0]  KeyStar = 4'd10;
  localparam logic [3:0]  KeyHash = 4'd11;
  localparam logic [3:0]  KeyNone = 4'd12;

  typedef enum logic [1:0] {StIdle, StQual, StHeld} state_e;

  state_e                  r_state;
  logic [3:0]              r_cand;
  logic [HitW-1:0]         r_hits;
  logic [IdleW-1:0]        r_idle;
  logic [4*MAX_DIGITS-1:0] r_digits;
  logic [CntW-1:0]         r_cnt;
  logic                    r_evt;
  logic [3:0]              r_evt_code;
  logic                    r_ovf;
  logic                    r_valid;

`ifdef KEYPAD_BACKSPACE_EN
  localparam int unsigned GapMax = RELEASE_CYCLES * 16;
  localparam int unsigned GapW   = $clog2(GapMax + 2);
  logic                    r_star_armed;
  logic [GapW-1:0]         r_star_gap;
`endif

  logic [3:0]              w_code;
  logic                    w_none;
  logic                    w_accept;
  logic [HitW-1:0]         w_hits_inc;
  logic [IdleW-1:0]        w_idle_inc;
  logic [4*MAX_DIGITS-1:0] w_shl;

  // Codes 13-15 are scanner idle states and count as "none".
  assign w_code     = (io_kp.key_code_in > KeyNone) ? KeyNone : io_kp.key_code_in;
  assign w_none     = (w_code == KeyNone);
  assign w_hits_inc = (r_hits == HitW'(PRESS_HITS)) ? r_hits : r_hits + HitW'(1);
  assign w_idle_inc = (r_idle == IdleW'(RELEASE_CYCLES)) ? r_idle : r_idle + IdleW'(1);
  assign w_shl      = (r_digits << 4) | (4*MAX_DIGITS)'(w_code);

  assign w_accept = !w_none &&
                    (((r_state == StQual) && (w_code == r_cand) &&
                      (w_hits_inc >= HitW'(PRESS_HITS))) ||
                     ((r_state == StIdle) && (PRESS_HITS <= 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cand     <= KeyNone;
      r_hits     <= '0;
      r_idle     <= '0;
      r_digits   <= '0;
      r_cnt      <= '0;
      r_evt      <= 1'b0;
      r_evt_code <= KeyNone;
      r_ovf      <= 1'b0;
      r_valid    <= 1'b0;
`ifdef KEYPAD_BACKSPACE_EN
      r_star_armed <= 1'b0;
      r_star_gap   <= '0;
`endif
    end else begin
      r_evt <= 1'b0;
      r_ovf <= 1'b0;

      unique case (r_state)
        StIdle: begin
          if (!w_none) begin
            r_cand  <= w_code;
            r_hits  <= HitW'(1);
            r_idle  <= '0;
            r_state <= w_accept ? StHeld : StQual;
          end
        end
        StQual: begin
          if (w_none) begin
            if (w_idle_inc >= IdleW'(RELEASE_CYCLES)) begin
              r_state <= StIdle;
              r_idle  <= '0;
              r_hits  <= '0;
            end else begin
              r_idle <= w_idle_inc;
            end
          end else if (w_code == r_cand) begin
            r_hits <= w_hits_inc;
            r_idle <= '0;
            if (w_accept) r_state <= StHeld;
          end else begin
            r_cand <= w_code;
            r_hits <= HitW'(1);
            r_idle <= '0;
          end
        end
        StHeld: begin
          if (!w_none) begin
            r_idle <= '0;
          end else if (w_idle_inc >= IdleW'(RELEASE_CYCLES)) begin
            r_state <= StIdle;
            r_idle  <= '0;
            r_hits  <= '0;
          end else begin
            r_idle <= w_idle_inc;
          end
        end
        default: r_state <= StIdle;
      endcase

      if (w_accept) begin
        r_evt      <= 1'b1;
        r_evt_code <= w_code;
      end

`ifdef KEYPAD_BACKSPACE_EN
      if (r_star_gap != GapW'(GapMax + 1)) r_star_gap <= r_star_gap + GapW'(1);
`endif

      // While an entry is offered the buffer is frozen and presses have no entry effect.
      if (r_valid) begin
        if (io_kp.code_ready) begin
          r_valid  <= 1'b0;
          r_digits <= '0;
          r_cnt    <= '0;
        end
      end else if (w_accept) begin
        if (w_code == KeyHash) begin
          if (r_cnt != '0) r_valid <= 1'b1;
        end else if (w_code == KeyStar) begin
`ifdef KEYPAD_BACKSPACE_EN
          if (r_star_armed && (r_star_gap <= GapW'(GapMax))) begin
            r_digits     <= '0;
            r_cnt        <= '0;
            r_star_armed <= 1'b0;
          end else begin
            if (r_cnt != '0) begin
              r_digits <= r_digits >> 4;
              r_cnt    <= r_cnt - CntW'(1);
            end
            r_star_armed <= 1'b1;
            r_star_gap   <= GapW'(1);
          end
`else
          r_digits <= '0;
          r_cnt    <= '0;
`endif
        end else if (r_cnt == CntW'(MAX_DIGITS)) begin
          r_ovf <= 1'b1;
        end else begin
          r_digits <= w_shl;
          r_cnt    <= r_cnt + CntW'(1);
        end
      end
    end
  end

  assign io_kp.digits       = r_digits;
  assign io_kp.digit_cnt    = r_cnt;
  assign io_kp.key_evt      = r_evt;
  assign io_kp.key_evt_code = r_evt_code;
  assign io_kp.overflow     = r_ovf;
  assign io_kp.code_valid   = r_valid;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed scenarios plus random presses against a
// run-length based reference model of press qualification and a digit queue.
module tb_keypad_entry_ctrl;
  localparam int unsigned MAX_DIGITS     = 4;
  localparam int unsigned PRESS_HITS     = 3;
  localparam int unsigned RELEASE_CYCLES = 8;
  localparam int          Gap            = RELEASE_CYCLES * 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_evt    = 0;
  int   n_ovf    = 0;

  keypad_entry_if #(.MAX_DIGITS(MAX_DIGITS)) kp_if ();

  keypad_entry_ctrl #(
    .MAX_DIGITS    (MAX_DIGITS),
    .PRESS_HITS    (PRESS_HITS),
    .RELEASE_CYCLES(RELEASE_CYCLES)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .io_kp(kp_if)
  );

  always #5 clk = ~clk;

  // Reference model: cand = -1 means no candidate, quiet = trailing run of "none" samples.
  int m_cand, m_hits, m_quiet, m_evt_code, m_cyc, m_last_star;
  bit m_held, m_evt, m_ovf, m_valid, m_armed;
  int m_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4*MAX_DIGITS-1:0] model_digits();
    logic [4*MAX_DIGITS-1:0] v = '0;
    foreach (m_q[i]) v = (v << 4) | (4*MAX_DIGITS)'(m_q[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_cand = -1; m_hits = 0; m_quiet = 0; m_held = 0;
    m_evt = 0; m_ovf = 0; m_valid = 0; m_evt_code = 12;
    m_armed = 0; m_last_star = 0; m_q.delete();
  endtask

  task automatic model_apply(input int k);
    if (k == 11) begin
      if (m_q.size() > 0) m_valid = 1;
    end else if (k == 10) begin
`ifdef KEYPAD_BACKSPACE_EN
      if (m_armed && (m_cyc - m_last_star) <= Gap) begin
        m_q.delete();
        m_armed = 0;
      end else begin
        if (m_q.size() > 0) void'(m_q.pop_back());
        m_armed = 1;
        m_last_star = m_cyc;
      end
`else
      m_q.delete();
`endif
    end else if (m_q.size() == MAX_DIGITS) begin
      m_ovf = 1;
    end else begin
      m_q.push_back(k);
    end
  endtask

  task automatic model_step(input int code, input bit ready);
    int c;
    bit acc = 0;
    bit was_valid = m_valid;
    c = (code > 12) ? 12 : code;
    m_cyc++;
    m_evt = 0;
    m_ovf = 0;
    m_quiet = (c == 12) ? m_quiet + 1 : 0;
    if (c == 12) begin
      if (m_cand >= 0 && m_quiet >= RELEASE_CYCLES) begin
        m_cand = -1;
        m_held = 0;
      end
    end else if (!m_held) begin
      if (c == m_cand) m_hits++;
      else begin
        m_cand = c;
        m_hits = 1;
      end
      if (m_hits >= PRESS_HITS) begin
        m_held = 1;
        acc = 1;
      end
    end
    if (acc) begin
      m_evt = 1;
      m_evt_code = m_cand;
    end
    if (was_valid) begin
      if (ready) begin
        m_valid = 0;
        m_q.delete();
      end
    end else if (acc) begin
      model_apply(m_cand);
    end
  endtask

  task automatic compare_all();
    check_eq("key_evt", 32'(kp_if.key_evt), 32'(m_evt));
    check_eq("key_evt_code", 32'(kp_if.key_evt_code), 32'(m_evt_code));
    check_eq("overflow", 32'(kp_if.overflow), 32'(m_ovf));
    check_eq("code_valid", 32'(kp_if.code_valid), 32'(m_valid));
    check_eq("digits", 32'(kp_if.digits), 32'(model_digits()));
    check_eq("digit_cnt", 32'(kp_if.digit_cnt), 32'(m_q.size()));
  endtask

  task automatic tick(input int code, input bit ready);
    kp_if.key_code_in = 4'(code);
    kp_if.code_ready  = ready;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(code, ready);
    #1;
    compare_all();
    if (kp_if.key_evt) n_evt++;
    if (kp_if.overflow) n_ovf++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(12, 0);
    rst = 1'b0;
  endtask

  // Scan-multiplexed press: key seen once per 4-sample scan, then released.
  task automatic press(input int k, input bit ready);
    for (int r = 0; r < PRESS_HITS; r++) begin
      tick(k, ready);
      for (int s = 0; s < 3; s++) tick(12, ready);
    end
    for (int s = 0; s < RELEASE_CYCLES; s++) tick(12, ready);
  endtask

  initial begin
    int seq1[9] = '{5, 12, 12, 12, 5, 12, 12, 12, 5};
    int seq3[5] = '{3, 3, 6, 6, 6};
    kp_if.key_code_in = 4'd12;
    kp_if.code_ready  = 1'b0;
    model_reset();
    m_cyc = 0;

    do_reset();
    check_eq("rst_code", 32'(kp_if.key_evt_code), 32'd12);
    check_eq("rst_cnt", 32'(kp_if.digit_cnt), 32'd0);

    // Single time-multiplexed press of 5.
    n_evt = 0;
    foreach (seq1[i]) tick(seq1[i], 0);
    check_eq("t1_evt", 32'(kp_if.key_evt), 32'd1);
    check_eq("t1_code", 32'(kp_if.key_evt_code), 32'd5);
    check_eq("t1_dig0", 32'(kp_if.digits[3:0]), 32'd5);
    check_eq("t1_cnt", 32'(kp_if.digit_cnt), 32'd1);
    for (int s = 0; s < 8; s++) tick(12, 0);
    check_eq("t1_nevt", 32'(n_evt), 32'd1);

    // Four digits, overflow, then submit with delayed ready.
    do_reset();
    press(1, 0); press(2, 0); press(3, 0); press(4, 0);
    check_eq("t2_dig", 32'(kp_if.digits), 32'h1234);
    n_ovf = 0;
    press(7, 0);
    check_eq("t2_novf", 32'(n_ovf), 32'd1);
    check_eq("t2_dig_ovf", 32'(kp_if.digits), 32'h1234);
    press(11, 0);
    for (int s = 0; s < 10; s++) tick(12, 0);
    check_eq("t2_valid_held", 32'(kp_if.code_valid), 32'd1);
    check_eq("t2_dig_held", 32'(kp_if.digits), 32'h1234);
    tick(12, 1);
    check_eq("t2_valid_done", 32'(kp_if.code_valid), 32'd0);
    check_eq("t2_cnt_done", 32'(kp_if.digit_cnt), 32'd0);
    check_eq("t2_dig_done", 32'(kp_if.digits), 32'd0);

    // Bounce rejection and candidate switching.
    do_reset();
    n_evt = 0;
    tick(9, 0); tick(12, 0); tick(12, 0); tick(12, 0); tick(9, 0);
    for (int s = 0; s < 8; s++) tick(12, 0);
    check_eq("t3_bounce", 32'(n_evt), 32'd0);
    foreach (seq3[i]) tick(seq3[i], 0);
    for (int s = 0; s < 8; s++) tick(12, 0);
    check_eq("t3_nevt", 32'(n_evt), 32'd1);
    check_eq("t3_code", 32'(kp_if.key_evt_code), 32'd6);

    // '#' on empty buffer, then '*' after 2,8.
    do_reset();
    press(11, 0);
    check_eq("t4_hash_empty", 32'(kp_if.code_valid), 32'd0);
    press(2, 0); press(8, 0); press(10, 0);
`ifdef KEYPAD_BACKSPACE_EN
    check_eq("t4_star_dig", 32'(kp_if.digits), 32'h0002);
    check_eq("t4_star_cnt", 32'(kp_if.digit_cnt), 32'd1);
`else
    check_eq("t4_star_cnt", 32'(kp_if.digit_cnt), 32'd0);
`endif

    // Reset while an entry is being offered.
    press(3, 0); press(11, 0);
    check_eq("t5_valid_pre", 32'(kp_if.code_valid), 32'd1);
    do_reset();
    check_eq("t5_valid", 32'(kp_if.code_valid), 32'd0);
    check_eq("t5_dig", 32'(kp_if.digits), 32'd0);
    check_eq("t5_code", 32'(kp_if.key_evt_code), 32'd12);

    // Random presses with bounce, noise codes, random ready and occasional reset.
    for (int p = 0; p < 250; p++) begin
      int k, nh, gap, rel;
      k = ($urandom_range(0, 5) == 0) ? int'($urandom_range(10, 11)) : int'($urandom_range(0, 9));
      nh = $urandom_range(1, 4);
      for (int h = 0; h < nh; h++) begin
        tick(k, $urandom_range(0, 3) == 0);
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++)
          tick(($urandom_range(0, 4) == 0) ? int'($urandom_range(13, 15)) : 12,
               $urandom_range(0, 3) == 0);
      end
      rel = $urandom_range(3, 10);
      for (int g = 0; g < rel; g++) tick(12, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
